// File: rtl/pc_fetch_unit.sv
// Program-counter fetch stage: issues word-aligned instruction-memory requests,
// hands each fetched word with its PC and PC+4 to decode, and accepts redirects.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc4,
    output logic        instr_valid,
    input  logic        dec_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        halt
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_OUT, S_HALTED} state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic        r_pend, w_pend_nxt;
    logic [31:0] r_pend_tgt, w_pend_tgt_nxt;
    logic [31:0] r_instr, w_instr_nxt;
    logic [31:0] r_instr_pc, w_instr_pc_nxt;
    logic [31:0] r_instr_pc4, w_instr_pc4_nxt;
    logic [31:0] w_tgt;
    logic [31:0] w_pc4;

    assign w_tgt = {redirect_target[31:2], 2'b00};
    assign w_pc4 = r_pc + 32'd4;

    assign imem_req    = (r_state == S_REQ);
    assign imem_addr   = r_pc;
    assign instr_valid = (r_state == S_OUT);
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_pc4   = r_instr_pc4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_pend      <= 1'b0;
            r_pend_tgt  <= '0;
            r_instr     <= '0;
            r_instr_pc  <= '0;
            r_instr_pc4 <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_pend      <= w_pend_nxt;
            r_pend_tgt  <= w_pend_tgt_nxt;
            r_instr     <= w_instr_nxt;
            r_instr_pc  <= w_instr_pc_nxt;
            r_instr_pc4 <= w_instr_pc4_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_pend_nxt      = r_pend;
        w_pend_tgt_nxt  = r_pend_tgt;
        w_instr_nxt     = r_instr;
        w_instr_pc_nxt  = r_instr_pc;
        w_instr_pc4_nxt = r_instr_pc4;
        case (r_state)
            S_IDLE: begin
                if (redirect_valid) begin
                    w_pc_nxt    = w_tgt;
                    w_state_nxt = S_REQ;
                end else if (halt) begin
                    w_state_nxt = S_HALTED;
                end else begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                // A redirect seen while the fetch is in flight kills the returned word.
                if (imem_ack) begin
                    if (redirect_valid) begin
                        w_pc_nxt   = w_tgt;
                        w_pend_nxt = 1'b0;
                    end else if (r_pend) begin
                        w_pc_nxt   = r_pend_tgt;
                        w_pend_nxt = 1'b0;
                    end else begin
                        w_instr_nxt     = imem_rdata;
                        w_instr_pc_nxt  = r_pc;
                        w_instr_pc4_nxt = w_pc4;
                        w_pc_nxt        = w_pc4;
                        w_state_nxt     = S_OUT;
                    end
                end else if (redirect_valid) begin
                    w_pend_nxt     = 1'b1;
                    w_pend_tgt_nxt = w_tgt;
                end
            end
            S_OUT: begin
                if (redirect_valid) begin
                    w_pc_nxt    = w_tgt;
                    w_state_nxt = S_REQ;
                end else if (dec_ready) begin
                    w_state_nxt = halt ? S_HALTED : S_REQ;
                end
            end
            S_HALTED: begin
                if (redirect_valid) begin
                    w_pc_nxt    = w_tgt;
                    w_state_nxt = S_REQ;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios plus randomized traffic, all checked
// against a transaction-level model of the fetch stage.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc4;
    logic        instr_valid;
    logic        dec_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        halt = 1'b0;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_pc4       (instr_pc4),
        .instr_valid     (instr_valid),
        .dec_ready       (dec_ready),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halt            (halt)
    );

    always #5 clk = ~clk;

    // Reference model: which phase of the fetch loop we are in, plus the
    // architectural PC, the deferred redirect and the word held for decode.
    typedef enum {M_IDLE, M_FETCH, M_HOLD, M_STOP} mphase_t;
    mphase_t     m_ph;
    logic [31:0] m_pc, m_pt, m_instr, m_ipc, m_ipc4;
    logic        m_pv;

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = M_IDLE; m_pc = 32'h0; m_pv = 1'b0; m_pt = '0;
        m_instr = '0; m_ipc = '0; m_ipc4 = '0;
    endtask

    task automatic model_update();
        logic [31:0] tgt;
        tgt = redirect_target & 32'hFFFF_FFFC;
        case (m_ph)
            M_IDLE: begin
                if (redirect_valid) begin m_pc = tgt; m_ph = M_FETCH; end
                else m_ph = halt ? M_STOP : M_FETCH;
            end
            M_FETCH: begin
                if (imem_ack) begin
                    if (redirect_valid) begin m_pc = tgt; m_pv = 1'b0; end
                    else if (m_pv) begin m_pc = m_pt; m_pv = 1'b0; end
                    else begin
                        m_instr = imem_rdata; m_ipc = m_pc; m_ipc4 = m_pc + 32'd4;
                        m_pc = m_pc + 32'd4; m_ph = M_HOLD;
                    end
                end else if (redirect_valid) begin
                    m_pv = 1'b1; m_pt = tgt;
                end
            end
            M_HOLD: begin
                if (redirect_valid) begin m_pc = tgt; m_ph = M_FETCH; end
                else if (dec_ready) m_ph = halt ? M_STOP : M_FETCH;
            end
            M_STOP: begin
                if (redirect_valid) begin m_pc = tgt; m_ph = M_FETCH; end
            end
        endcase
    endtask

    task automatic check_all(input string tag);
        check32({tag, ".req"},   {31'b0, imem_req},    {31'b0, m_ph == M_FETCH});
        check32({tag, ".addr"},  imem_addr,            m_pc);
        check32({tag, ".valid"}, {31'b0, instr_valid}, {31'b0, m_ph == M_HOLD});
        if (m_ph == M_HOLD) begin
            check32({tag, ".instr"}, instr,     m_instr);
            check32({tag, ".pc"},    instr_pc,  m_ipc);
            check32({tag, ".pc4"},   instr_pc4, m_ipc4);
        end
    endtask

    // Drive one cycle of inputs, advance past the edge, then compare.
    task automatic step(input logic ack, input logic rdy, input logic rv,
                        input logic [31:0] tgt, input logic hlt, input string tag);
        imem_ack        = ack && (m_ph == M_FETCH);
        imem_rdata      = m_pc ^ 32'hA5A5_0000;
        dec_ready       = rdy;
        redirect_valid  = rv;
        redirect_target = tgt;
        halt            = hlt;
        @(posedge clk);
        model_update();
        #1;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        check32("reset.instr", instr, 32'h0);
        check32("reset.pc4", instr_pc4, 32'h0);
        rst_n = 1'b1;

        // Zero-wait memory, decode always ready.
        step(0, 1, 0, 0, 0, "idle");
        check32("zw.addr0", imem_addr, 32'h0);
        step(1, 1, 0, 0, 0, "zw0");
        check32("zw.instr0", instr, 32'hA5A5_0000);
        step(0, 1, 0, 0, 0, "zw1r");
        check32("zw.addr4", imem_addr, 32'h4);
        step(1, 1, 0, 0, 0, "zw1");
        step(0, 1, 0, 0, 0, "zw2r");
        step(1, 1, 0, 0, 0, "zw2");
        check32("zw.pc8", instr_pc, 32'h8);
        check32("zw.pc4_12", instr_pc4, 32'hC);

        // Redirect while holding an instruction.
        step(0, 0, 1, 32'h0000_0103, 0, "rdout");
        check32("rdout.valid", {31'b0, instr_valid}, 32'h0);
        check32("rdout.addr", imem_addr, 32'h100);
        step(1, 1, 0, 0, 0, "rd100");
        step(0, 1, 0, 0, 0, "rd104r");
        check32("rd.addr104", imem_addr, 32'h104);

        // Memory wait states, then decode back-pressure.
        repeat (3) step(0, 1, 0, 0, 0, "wait");
        check32("wait.addr", imem_addr, 32'h104);
        step(1, 0, 0, 0, 0, "wack");
        step(0, 0, 0, 0, 0, "stall1");
        step(0, 0, 0, 0, 0, "stall2");
        check32("stall.pc", instr_pc, 32'h104);
        step(0, 1, 0, 0, 0, "stallrel");
        check32("stall.next", imem_addr, 32'h108);

        // Two pending redirects before ack: last wins, word discarded.
        step(0, 0, 1, 32'h200, 0, "pend1");
        step(0, 0, 1, 32'h300, 0, "pend2");
        check32("pend.addr_old", imem_addr, 32'h108);
        step(1, 0, 0, 0, 0, "pendack");
        check32("pend.valid", {31'b0, instr_valid}, 32'h0);
        check32("pend.addr", imem_addr, 32'h300);
        // Pending redirect overridden by a same-cycle redirect at ack.
        step(0, 0, 1, 32'h500, 0, "pr1");
        step(1, 0, 1, 32'h600, 0, "pr2");
        check32("prio.addr", imem_addr, 32'h600);
        step(1, 1, 0, 0, 0, "pr600");

        // Flush with dec_ready high, then 32-bit wrap.
        step(0, 1, 1, 32'hFFFF_FFFF, 0, "wrapr");
        check32("wrap.addr", imem_addr, 32'hFFFF_FFFC);
        step(1, 1, 0, 0, 0, "wrap");
        check32("wrap.pc4", instr_pc4, 32'h0);
        step(0, 1, 0, 0, 0, "wrapn");
        check32("wrap.next", imem_addr, 32'h0);

        // Halt: fetch at 0x10 completes, then stop; redirect restarts.
        step(1, 1, 1, 32'h10, 0, "h_rd");
        check32("halt.addr10", imem_addr, 32'h10);
        step(0, 0, 0, 0, 1, "h_wait");
        step(1, 0, 0, 0, 1, "h_ack");
        check32("halt.pc", instr_pc, 32'h10);
        step(0, 1, 0, 0, 1, "h_stop");
        check32("halt.req", {31'b0, imem_req}, 32'h0);
        step(0, 1, 0, 0, 0, "h_stay");
        step(0, 0, 1, 32'h40, 1, "h_restart");
        check32("halt.restart", imem_addr, 32'h40);

        // Asynchronous reset in the middle of a request.
        step(0, 0, 0, 0, 0, "pre_rst");
        #1 rst_n = 1'b0;
        #1;
        check32("arst.req", {31'b0, imem_req}, 32'h0);
        check32("arst.addr", imem_addr, 32'h0);
        model_reset();
        check_all("arst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1, 1, 0, 0, 0, "arst_idle");
        step(1, 1, 0, 0, 0, "arst_f0");
        check32("arst.restart", instr_pc, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 1) == 1), ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 9) == 0), $urandom(),
                 ($urandom_range(0, 9) == 0), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
